quad_encoder_array: RTL and testbench
=====================================

// Module: quad_encoder_array
// PURPOSE
//  N-channel 4x quadrature decoder. Each channel keeps a signed position and a windowed velocity,
//  and flags illegal transitions. Registers are read and controlled over the 8-bit peripheral bus
//  (addr/cs/rd/wr), the same bus as the other peripherals.
//  Generalises the single-channel step counter:
//    - direction-aware (up/down) counting
//    - synchronised inputs
//    - velocity
//    - atomic multi-byte reads
// PARAMETERS
//  N_CH        2      number of encoder channels (1..8)
//  CNT_W       16     position width, signed, wraps modulo 2^CNT_W (8..16)
//  VEL_W       16     velocity width, signed, saturating (8..16)
//  WIN_CYCLES  50000  velocity gate length in clk cycles (>=2)
//  SYNC_STAGES 2      input synchroniser flops per A/B line (>=2)
//  BASE_ADDR   16'h0000  base of this block's 8-byte-per-channel register window
// PORTS
//  clk       in   1         system clock
//  rst       in   1         synchronous, active-high reset
//  addr      in   16        bus address
//  data_in   in   8         bus write data
//  cs        in   1         chip select
//  rd        in   1         read strobe (with cs)
//  wr        in   1         write strobe (with cs)
//  data_out  out  8         registered read data
//  A         in   N_CH      encoder phase A, one bit per channel, asynchronous
//  B         in   N_CH      encoder phase B, one bit per channel, asynchronous
//  irq       out  1         OR of all channels' sticky error flags
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-high.
//   - rst=1 at a clk edge clears: synchronisers, prev-state, position, velocity,
//     window counter/accumulator, error flags, shadow regs.
//   - data_out=0, irq=0. Reset mid-window discards the partial window.
//  Sync: A/B pass SYNC_STAGES flops. Decode operates on synced {A,B} vs previous synced pair.
//  Decode, Gray order 00->01->11->10->00:
//   - forward step = +1; reverse step = -1; no change = 0.
//   - two-bit change (00<->11, 01<->10) = illegal: no count, set err sticky.
//  Position: pos <= pos + step, two's complement wrap (0x7FFF+1 -> 0x8000 at CNT_W=16).
//  Velocity:
//   - wcnt counts 0..WIN_CYCLES-1; acc sums steps.
//   - At wcnt==WIN_CYCLES-1, that cycle's step is included. vel <= sat(acc+step), acc <= 0.
//   - sat clamps to [-2^(VEL_W-1), 2^(VEL_W-1)-1]. acc is wide enough not to overflow (>= clog2(WIN_CYCLES)+1 bits).
//  Direction bit dir = sign of the last nonzero step (1 = reverse).
//  Register map, channel c, byte offset o, address BASE_ADDR + 8*c + o:
//   - o=0  POS_L
//     Read returns pos[7:0] and latches pos[15:8] into shadow_p (same cycle).
//   - o=1  POS_H   returns shadow_p.
//   - o=2  VEL_L
//     Read returns vel[7:0] and latches vel[15:8] into shadow_v.
//   - o=3  VEL_H   returns shadow_v.
//   - o=4  STAT    returns {4'b0, err, dir, syncA, syncB}.
//   - o=5  CTRL    write only; read returns 0.
//     data_in[0]=1 clears pos; data_in[1]=1 clears err.
//   - o=6,7 reserved, read 0.
//   - Values narrower than 16 bits are sign-extended.
//  Read timing:
//   - data_out updates the cycle after cs&rd; 1-cycle latency.
//   - Returns 0 when cs&rd is low or the address is unmapped; never tri-stated.
//  Write: cs&wr takes effect at that clk edge. cs&rd&wr together: the write is ignored, the read proceeds.
//  Simultaneous events:
//   - clear-pos and step in the same cycle -> pos=0 (clear wins; step still counts into acc).
//   - clear-err and a new illegal transition in the same cycle -> err stays 1.
//  irq = |err[N_CH-1:0], registered; level until cleared.
// STRUCTURE
//  quad_enc_pkg:
//   - register offset localparams (OFF_POS_L..OFF_CTRL)
//   - CTRL bit indices
//   - STEP encoding constants (+1/0/-1)
//  Sub-module quad_channel: one per channel via generate.
//   - contains synchroniser, decoder, pos, vel window, err, dir.
//  Top holds address decode, shadow regs, data_out mux, irq.
// TESTING
//  - Reset: hold rst 2 cycles, then read all regs of ch0/ch1
//    -> every byte 0x00, irq=0.
//  - Forward/wrap: ch0 gets 4 forward Gray steps from pos 0x7FFE
//    -> POS_L/POS_H read 0x02,0x80 (0x8002); STAT.dir=0.
//  - Reverse/velocity: WIN_CYCLES=100, ch1 gets 10 reverse steps inside one window
//    -> VEL after window = 0xFFF6 (-10); next window with no steps -> 0x0000.
//  - Illegal: ch0 jumps 00->11
//    -> pos unchanged, STAT.err=1, irq=1. Write CTRL=0x02 -> err=0, irq=0 next cycle.
//  - Atomic read: read POS_L (0x34), step 256 times, read POS_H
//    -> returns the latched MSB (0x12 for pos 0x1234), not the new one.
//  - Collisions: CTRL clear-pos coincides with a step
//    -> pos=0; a step on the last window cycle is included in the latched vel.

Source files
------------

// File: rtl/quad_enc_pkg.sv
// rtl/quad_enc_pkg.sv - shared constants and decode helper for the quadrature encoder array
//
// Purpose: register offsets, CTRL bit positions, step encodings and the Gray-code
//          transition decoder used by every encoder channel.
// Ports:   none (package).

package quad_enc_pkg;

  // Byte offsets inside a channel's 8-byte register window
  localparam logic [2:0] OFF_POS_L = 3'd0;
  localparam logic [2:0] OFF_POS_H = 3'd1;
  localparam logic [2:0] OFF_VEL_L = 3'd2;
  localparam logic [2:0] OFF_VEL_H = 3'd3;
  localparam logic [2:0] OFF_STAT  = 3'd4;
  localparam logic [2:0] OFF_CTRL  = 3'd5;

  // CTRL write bits
  localparam int CTRL_CLR_POS = 0;
  localparam int CTRL_CLR_ERR = 1;

  // Step encoding: a 2-bit two's complement value, so sign extension yields +1/0/-1
  localparam logic [1:0] STEP_NONE = 2'b00;
  localparam logic [1:0] STEP_FWD  = 2'b01;
  localparam logic [1:0] STEP_REV  = 2'b11;

  typedef struct packed {
    logic       illegal;
    logic [1:0] step;
  } dec_t;

  // Position of an {A,B} pair along the forward cycle 00->01->11->10
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] p;
    case (ab)
      2'b00:   p = 2'd0;
      2'b01:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  // Modulo-4 distance between the two positions tells the transition type:
  // 1 = forward, 3 = reverse, 2 = both lines changed (illegal), 0 = idle.
  function automatic dec_t decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    dec_t       d;
    logic [1:0] diff;
    diff = gray_pos(cur_ab) - gray_pos(prev_ab);
    d.illegal = 1'b0;
    d.step    = STEP_NONE;
    case (diff)
      2'd1:    d.step    = STEP_FWD;
      2'd3:    d.step    = STEP_REV;
      2'd2:    d.illegal = 1'b1;
      default: d.step    = STEP_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/quad_encoder_array_channel.sv
// rtl/quad_encoder_array_channel.sv - one quadrature channel: sync, decode, position, velocity, error
//
// Purpose: decodes one A/B encoder pair into a signed wrapping position, a windowed saturating
//          velocity, a sticky illegal-transition flag and the last direction.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   a, b              asynchronous encoder phases
//   clr_pos, clr_err  one-cycle clear strobes from the register block
//   pos_ext, vel_ext  position / velocity sign-extended to 16 bits
//   err, dir          sticky illegal flag, direction of last step (1 = reverse)
//   sync_a, sync_b    synchronised phase levels

module quad_channel
  import quad_enc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int VEL_W       = 16,
  parameter int WIN_CYCLES  = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        clr_pos,
  input  logic        clr_err,
  output logic [15:0] pos_ext,
  output logic [15:0] vel_ext,
  output logic        err,
  output logic        dir,
  output logic        sync_a,
  output logic        sync_b
);

  localparam int WCNT_W = $clog2(WIN_CYCLES);
  // Two spare bits: one for the sign, one so a full window of steps cannot overflow
  localparam int ACC_W  = WCNT_W + 2;
  localparam logic [31:0] VMAX = (32'd1 << (VEL_W - 1)) - 32'd1;
  localparam logic [31:0] VMIN = ~VMAX;

  logic [SYNC_STAGES-1:0] sa_q;
  logic [SYNC_STAGES-1:0] sb_q;
  logic [1:0]             prev_ab;
  logic [1:0]             cur_ab;
  dec_t                   dec;
  logic [CNT_W-1:0]       pos;
  logic [CNT_W-1:0]       pos_step;
  logic [VEL_W-1:0]       vel;
  logic [VEL_W-1:0]       vel_sat;
  logic [WCNT_W-1:0]      wcnt;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_sum;
  logic [31:0]            sum32;
  logic                   win_end;

  assign cur_ab   = {sa_q[SYNC_STAGES-1], sb_q[SYNC_STAGES-1]};
  assign dec      = decode(prev_ab, cur_ab);
  assign pos_step = {{(CNT_W-2){dec.step[1]}}, dec.step};
  assign acc_sum  = acc + {{(ACC_W-2){dec.step[1]}}, dec.step};
  assign sum32    = {{(32-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
  assign win_end  = (wcnt == WCNT_W'(WIN_CYCLES - 1));

  assign sync_a = sa_q[SYNC_STAGES-1];
  assign sync_b = sb_q[SYNC_STAGES-1];

  // The closing window value already includes this cycle's step
  always_comb begin
    vel_sat = sum32[VEL_W-1:0];
    if ($signed(sum32) > $signed(VMAX)) begin
      vel_sat = VMAX[VEL_W-1:0];
    end else if ($signed(sum32) < $signed(VMIN)) begin
      vel_sat = VMIN[VEL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q    <= '0;
      sb_q    <= '0;
      prev_ab <= 2'b00;
      pos     <= '0;
      vel     <= '0;
      wcnt    <= '0;
      acc     <= '0;
      err     <= 1'b0;
      dir     <= 1'b0;
    end else begin
      sa_q    <= {sa_q[SYNC_STAGES-2:0], a};
      sb_q    <= {sb_q[SYNC_STAGES-2:0], b};
      prev_ab <= cur_ab;

      // A clear beats a coincident step; the step still reaches the velocity sum
      if (clr_pos) begin
        pos <= '0;
      end else begin
        pos <= pos + pos_step;
      end

      if (win_end) begin
        wcnt <= '0;
        acc  <= '0;
        vel  <= vel_sat;
      end else begin
        wcnt <= wcnt + 1'b1;
        acc  <= acc_sum;
      end

      // A new illegal transition outranks a coincident clear
      if (dec.illegal) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end

      if (dec.step != STEP_NONE) begin
        dir <= dec.step[1];
      end
    end
  end

  generate
    if (CNT_W < 16) begin : g_pos_sx
      assign pos_ext = {{(16-CNT_W){pos[CNT_W-1]}}, pos};
    end else begin : g_pos_full
      assign pos_ext = pos;
    end
    if (VEL_W < 16) begin : g_vel_sx
      assign vel_ext = {{(16-VEL_W){vel[VEL_W-1]}}, vel};
    end else begin : g_vel_full
      assign vel_ext = vel;
    end
  endgenerate

endmodule

// File: rtl/quad_encoder_array.sv
// rtl/quad_encoder_array.sv - N-channel quadrature decoder with 8-bit peripheral bus registers
//
// Purpose: instantiates one quad_channel per encoder and maps them into an 8-byte-per-channel
//          register window; POS_L / VEL_L reads freeze the high byte so 16-bit values read
//          atomically as two bytes.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   addr, data_in         bus address / write data
//   cs, rd, wr            chip select, read strobe, write strobe
//   data_out              registered read data, 0 when not reading
//   A, B                  encoder phases, one bit per channel, asynchronous
//   irq                   OR of all sticky error flags, registered

module quad_encoder_array
  import quad_enc_pkg::*;
#(
  parameter int          N_CH        = 2,
  parameter int          CNT_W       = 16,
  parameter int          VEL_W       = 16,
  parameter int          WIN_CYCLES  = 50000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] BASE_ADDR   = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     addr,
  input  logic [7:0]      data_in,
  input  logic            cs,
  input  logic            rd,
  input  logic            wr,
  output logic [7:0]      data_out,
  input  logic [N_CH-1:0] A,
  input  logic [N_CH-1:0] B,
  output logic            irq
);

  localparam int WIN_BYTES = 8 * N_CH;

  logic [15:0]     pos_ext [N_CH];
  logic [15:0]     vel_ext [N_CH];
  logic [7:0]      shadow_p [N_CH];
  logic [7:0]      shadow_v [N_CH];
  logic [N_CH-1:0] err_v;
  logic [N_CH-1:0] dir_v;
  logic [N_CH-1:0] sa_v;
  logic [N_CH-1:0] sb_v;
  logic [N_CH-1:0] clr_pos_v;
  logic [N_CH-1:0] clr_err_v;

  logic [16:0] rel;
  logic        hit;
  logic [2:0]  sel_ch;
  logic [2:0]  sel_off;
  logic        rd_hit;
  logic        wr_ctrl;
  logic [7:0]  rd_data;
  logic        unused_data;

  // Bit 16 of the difference is the borrow, i.e. addr below the window
  assign rel     = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign hit     = ~rel[16] && (rel < 17'(WIN_BYTES));
  assign sel_ch  = rel[5:3];
  assign sel_off = rel[2:0];

  assign rd_hit  = cs & rd & hit;
  // A combined read+write strobe is treated as a read only
  assign wr_ctrl = cs & wr & ~rd & hit & (sel_off == OFF_CTRL);

  assign unused_data = &{1'b0, data_in[7:2]};

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign clr_pos_v[c] = wr_ctrl & (sel_ch == 3'(c)) & data_in[CTRL_CLR_POS];
      assign clr_err_v[c] = wr_ctrl & (sel_ch == 3'(c)) & data_in[CTRL_CLR_ERR];

      quad_channel #(
        .CNT_W       (CNT_W),
        .VEL_W       (VEL_W),
        .WIN_CYCLES  (WIN_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .a       (A[c]),
        .b       (B[c]),
        .clr_pos (clr_pos_v[c]),
        .clr_err (clr_err_v[c]),
        .pos_ext (pos_ext[c]),
        .vel_ext (vel_ext[c]),
        .err     (err_v[c]),
        .dir     (dir_v[c]),
        .sync_a  (sa_v[c]),
        .sync_b  (sb_v[c])
      );
    end
  endgenerate

  always_comb begin
    rd_data = 8'h00;
    for (int c = 0; c < N_CH; c++) begin
      if (sel_ch == 3'(c)) begin
        case (sel_off)
          OFF_POS_L: rd_data = pos_ext[c][7:0];
          OFF_POS_H: rd_data = shadow_p[c];
          OFF_VEL_L: rd_data = vel_ext[c][7:0];
          OFF_VEL_H: rd_data = shadow_v[c];
          OFF_STAT:  rd_data = {4'b0000, err_v[c], dir_v[c], sa_v[c], sb_v[c]};
          default:   rd_data = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 8'h00;
      irq      <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        shadow_p[c] <= 8'h00;
        shadow_v[c] <= 8'h00;
      end
    end else begin
      data_out <= rd_hit ? rd_data : 8'h00;
      irq      <= |err_v;
      // Low-byte reads freeze the matching high byte for the follow-up read
      for (int c = 0; c < N_CH; c++) begin
        if (rd_hit && (sel_ch == 3'(c)) && (sel_off == OFF_POS_L)) begin
          shadow_p[c] <= pos_ext[c][15:8];
        end
        if (rd_hit && (sel_ch == 3'(c)) && (sel_off == OFF_VEL_L)) begin
          shadow_v[c] <= vel_ext[c][15:8];
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_array.sv
// tb/tb_quad_encoder_array.sv - directed self-checking bench for quad_encoder_array

module tb_quad_encoder_array;

  localparam int          WIN  = 100;
  localparam logic [15:0] BASE = 16'h0040;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        cs, rd, wr;
  logic [7:0]  data_out;
  logic [1:0]  A, B;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  int idx [2];
  int tcnt;

  quad_encoder_array #(
    .N_CH(2), .CNT_W(16), .VEL_W(16), .WIN_CYCLES(WIN), .SYNC_STAGES(2), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .cs(cs), .rd(rd), .wr(wr),
    .data_out(data_out), .A(A), .B(B), .irq(irq)
  );

  always #5 clk = ~clk;

  // Independent window phase tracker: 0 on the cycle after reset, wraps at WIN
  always @(posedge clk) begin
    if (rst) tcnt <= 0;
    else if (tcnt == WIN - 1) tcnt <= 0;
    else tcnt <= tcnt + 1;
  end

  function automatic logic [15:0] ra(input int c, input int o);
    return BASE + 16'(8 * c + o);
  endfunction

  function automatic logic [1:0] gray_ab(input int i);
    case (i)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input int c, input bit fwd);
    idx[c] = fwd ? (idx[c] + 1) % 4 : (idx[c] + 3) % 4;
    {A[c], B[c]} = gray_ab(idx[c]);
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    addr = a; cs = 1'b1; rd = 1'b1;
    @(negedge clk);
    d = data_out;
    cs = 1'b0; rd = 1'b0; addr = 16'h0000;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
    addr = a; data_in = v; cs = 1'b1; wr = 1'b1;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 8'h00;
  endtask

  task automatic wait_wcnt(input int v);
    int n = 0;
    while (tcnt != v && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tcnt != v) begin
      miscompares++;
      $display("FAIL wait_wcnt: window phase %0d, required %0d", tcnt, v);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; A = 2'b00; B = 2'b00; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = 16'h0000; data_in = 8'h00; idx[0] = 0; idx[1] = 0;
    idle(2);
    rst = 1'b0;
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b required 0", irq); end
    for (int c = 0; c < 2; c++) begin
      for (int o = 0; o < 8; o++) begin
        bus_read(ra(c, o), d);
        vectors++;
        if (d !== 8'h00) begin
          miscompares++;
          $display("FAIL reset_reg ch%0d off%0d: got %h required 00", c, o, d);
        end
      end
    end
  endtask

  task automatic test_forward_wrap();
    logic [7:0] d;
    for (int i = 0; i < 32766; i++) step(0, 1'b1);
    idle(4);
    bus_read(ra(0, 0), d);
    vectors++; if (d !== 8'hFE) begin miscompares++; $display("FAIL pos_7ffe_l: got %h required fe", d); end
    bus_read(ra(0, 1), d);
    vectors++; if (d !== 8'h7F) begin miscompares++; $display("FAIL pos_7ffe_h: got %h required 7f", d); end
    for (int i = 0; i < 4; i++) step(0, 1'b1);
    idle(4);
    bus_read(ra(0, 0), d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL wrap_pos_l: got %h required 02", d); end
    bus_read(ra(0, 1), d);
    vectors++; if (d !== 8'h80) begin miscompares++; $display("FAIL wrap_pos_h: got %h required 80", d); end
    bus_read(ra(0, 4), d);
    vectors++; if (d !== 8'h03) begin miscompares++; $display("FAIL wrap_stat: got %h required 03", d); end
  endtask

  task automatic test_reverse_velocity();
    logic [7:0] d;
    wait_wcnt(10);
    for (int i = 0; i < 10; i++) step(1, 1'b0);
    wait_wcnt(WIN - 1);
    wait_wcnt(50);
    bus_read(ra(1, 2), d);
    vectors++; if (d !== 8'hF6) begin miscompares++; $display("FAIL vel_neg10_l: got %h required f6", d); end
    bus_read(ra(1, 3), d);
    vectors++; if (d !== 8'hFF) begin miscompares++; $display("FAIL vel_neg10_h: got %h required ff", d); end
    bus_read(ra(1, 0), d);
    vectors++; if (d !== 8'hF6) begin miscompares++; $display("FAIL rev_pos_l: got %h required f6", d); end
    bus_read(ra(1, 1), d);
    vectors++; if (d !== 8'hFF) begin miscompares++; $display("FAIL rev_pos_h: got %h required ff", d); end
    bus_read(ra(1, 4), d);
    vectors++; if (d !== 8'h07) begin miscompares++; $display("FAIL rev_stat: got %h required 07", d); end
    wait_wcnt(WIN - 1);
    wait_wcnt(50);
    bus_read(ra(1, 2), d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL vel_idle_l: got %h required 00", d); end
    bus_read(ra(1, 3), d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL vel_idle_h: got %h required 00", d); end
  endtask

  task automatic test_window_edge();
    logic [7:0] d;
    // Driven now, the step reaches the decoder on the edge closing the window
    wait_wcnt(WIN - 3);
    step(1, 1'b1);
    wait_wcnt(10);
    bus_read(ra(1, 2), d);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("FAIL vel_last_cycle_l: got %h required 01", d); end
    bus_read(ra(1, 3), d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL vel_last_cycle_h: got %h required 00", d); end
  endtask

  task automatic test_clear_pos_collision();
    logic [7:0] d;
    step(0, 1'b1);
    @(negedge clk);
    bus_write(ra(0, 5), 8'h01);
    idle(4);
    bus_read(ra(0, 0), d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL clr_vs_step_l: got %h required 00", d); end
    bus_read(ra(0, 1), d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL clr_vs_step_h: got %h required 00", d); end
  endtask

  task automatic test_illegal();
    logic [7:0] d;
    step(0, 1'b1);                 // back to 00
    idle(4);
    bus_write(ra(0, 5), 8'h01);
    idle(2);
    A[0] = 1'b1; B[0] = 1'b1; idx[0] = 2;
    idle(5);
    bus_read(ra(0, 0), d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL illegal_pos_l: got %h required 00", d); end
    bus_read(ra(0, 1), d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL illegal_pos_h: got %h required 00", d); end
    bus_read(ra(0, 4), d);
    vectors++; if (d !== 8'h0B) begin miscompares++; $display("FAIL illegal_stat: got %h required 0b", d); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL illegal_irq: got %b required 1", irq); end
    bus_write(ra(0, 5), 8'h02);
    @(negedge clk);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL clr_err_irq: got %b required 0", irq); end
    bus_read(ra(0, 4), d);
    vectors++; if (d !== 8'h03) begin miscompares++; $display("FAIL clr_err_stat: got %h required 03", d); end
    // Clear-err lands on the same edge as a fresh illegal jump 11->00
    A[0] = 1'b0; B[0] = 1'b0; idx[0] = 0;
    @(negedge clk);
    @(negedge clk);
    bus_write(ra(0, 5), 8'h02);
    idle(2);
    bus_read(ra(0, 4), d);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL err_vs_clr_stat: got %h required 08", d); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL err_vs_clr_irq: got %b required 1", irq); end
    bus_write(ra(0, 5), 8'h02);
    idle(2);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL final_clr_irq: got %b required 0", irq); end
  endtask

  task automatic test_atomic_read();
    logic [7:0] d;
    for (int i = 0; i < 4660; i++) step(0, 1'b1);
    idle(4);
    bus_read(ra(0, 0), d);
    vectors++; if (d !== 8'h34) begin miscompares++; $display("FAIL atomic_l: got %h required 34", d); end
    for (int i = 0; i < 256; i++) step(0, 1'b1);
    idle(4);
    bus_read(ra(0, 1), d);
    vectors++; if (d !== 8'h12) begin miscompares++; $display("FAIL atomic_h_latched: got %h required 12", d); end
    bus_read(ra(0, 0), d);
    vectors++; if (d !== 8'h34) begin miscompares++; $display("FAIL atomic_l2: got %h required 34", d); end
    bus_read(ra(0, 1), d);
    vectors++; if (d !== 8'h13) begin miscompares++; $display("FAIL atomic_h_new: got %h required 13", d); end
  endtask

  task automatic test_bus_edges();
    logic [7:0] d;
    // Simultaneous read and write of CTRL: read returns 0, clear must not happen
    addr = ra(0, 5); data_in = 8'h01; cs = 1'b1; rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL rdwr_data: got %h required 00", data_out); end
    cs = 1'b0; rd = 1'b0; wr = 1'b0; data_in = 8'h00;
    idle(1);
    bus_read(ra(0, 0), d);
    vectors++; if (d !== 8'h34) begin miscompares++; $display("FAIL rdwr_pos_kept: got %h required 34", d); end
    @(negedge clk);
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL idle_data_out: got %h required 00", data_out); end
    bus_read(16'h0050, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL unmapped_above: got %h required 00", d); end
    bus_read(16'h0030, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL unmapped_below: got %h required 00", d); end
    bus_read(ra(0, 6), d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reserved_off6: got %h required 00", d); end
  endtask

  initial begin
    test_reset();
    test_forward_wrap();
    test_reverse_velocity();
    test_window_edge();
    test_clear_pos_collision();
    test_illegal();
    test_atomic_read();
    test_bus_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
